event_sync_arbiter: RTL

- Collects edge events from NUM_CH asynchronous sources (keypads, external strobes, other clock domains) into the clk domain.
- Holds each event as a pending flag and presents the events one at a time to a single downstream consumer.
- Uses round-robin arbitration with a valid/ready handshake.
- Sits between the asynchronous event sources and the consumer logic, such as an FSM or LCD/audio controller, that services one event per transaction.

---
 rtl/event_sync_arbiter.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/event_sync_arbiter.sv
// Synchronizes rising edges from NUM_CH async lines into pending flags and presents them one at a time, round-robin.
// Edge to pending is SYNC_STAGES+1 cycles, pending to event_valid 1 cycle; event_valid/event_id hold until event_ready.
module event_sync_arbiter #(
  parameter int NUM_CH      = 4,
  parameter int ID_W        = 2,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              clr_n,
  input  logic [NUM_CH-1:0] async_sig,
  input  logic [NUM_CH-1:0] ch_enable,
  output logic              event_valid,
  output logic [ID_W-1:0]   event_id,
  input  logic              event_ready,
  output logic [NUM_CH-1:0] pending,
  output logic [NUM_CH-1:0] overflow,
  input  logic              ovf_clear
);

  localparam int WARM_W = $clog2(SYNC_STAGES + 2);

  typedef enum logic {IDLE, PRESENT} state_t;

  logic [SYNC_STAGES-1:0][NUM_CH-1:0] sync_q;
  logic [NUM_CH-1:0]                  hist_q;
  logic [WARM_W-1:0]                  warm_cnt;
  logic                               warm_done;
  logic [NUM_CH-1:0]                  sync_out;
  logic [NUM_CH-1:0]                  rise;

  state_t            state_q, state_nxt;
  logic [ID_W-1:0]   ptr_q, ptr_nxt;
  logic [ID_W-1:0]   id_q, id_nxt;
  logic [NUM_CH-1:0] req;
  logic              found;
  logic [ID_W-1:0]   grant;
  logic              cur_en;
  logic              accept;
  logic [NUM_CH-1:0] acc_vec;
  logic [NUM_CH-1:0] pending_nxt;
  logic [NUM_CH-1:0] overflow_nxt;

  assign sync_out  = sync_q[SYNC_STAGES-1];
  assign warm_done = (warm_cnt == WARM_W'(SYNC_STAGES + 1));
  // Edges are masked until the history flop has caught up with the synchronizer after reset.
  assign rise      = warm_done ? (sync_out & ~hist_q) : '0;

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      sync_q   <= '0;
      hist_q   <= '0;
      warm_cnt <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], async_sig};
      hist_q <= sync_out;
      if (!warm_done) warm_cnt <= warm_cnt + 1'b1;
    end
  end

  always_comb begin
    cur_en  = 1'b0;
    acc_vec = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (id_q == ID_W'(i)) cur_en = ch_enable[i];
    end
    accept = (state_q == PRESENT) && event_ready && cur_en;
    for (int i = 0; i < NUM_CH; i++) begin
      acc_vec[i] = accept && (id_q == ID_W'(i));
    end
  end

  // A rise coinciding with the accept re-arms the channel rather than counting as overflow.
  always_comb begin
    pending_nxt  = '0;
    overflow_nxt = ovf_clear ? '0 : overflow;
    for (int i = 0; i < NUM_CH; i++) begin
      pending_nxt[i] = ch_enable[i] && (rise[i] || (pending[i] && !acc_vec[i]));
      if (ch_enable[i] && rise[i] && pending[i] && !acc_vec[i]) overflow_nxt[i] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      pending  <= '0;
      overflow <= '0;
    end else begin
      pending  <= pending_nxt;
      overflow <= overflow_nxt;
    end
  end

  // Round-robin search starting one past the last granted channel.
  always_comb begin
    req   = pending & ch_enable;
    found = 1'b0;
    grant = '0;
    for (int off = 1; off <= NUM_CH; off++) begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (!found && req[i] && (i == (int'(ptr_q) + off) % NUM_CH)) begin
          found = 1'b1;
          grant = ID_W'(i);
        end
      end
    end
  end

  always_comb begin
    state_nxt = state_q;
    ptr_nxt   = ptr_q;
    id_nxt    = id_q;
    case (state_q)
      IDLE: begin
        if (found) begin
          state_nxt = PRESENT;
          id_nxt    = grant;
        end
      end
      PRESENT: begin
        if (!cur_en) begin
          state_nxt = IDLE;
        end else if (event_ready) begin
          state_nxt = IDLE;
          ptr_nxt   = id_q;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state_q <= IDLE;
      ptr_q   <= ID_W'(NUM_CH - 1);
      id_q    <= '0;
    end else begin
      state_q <= state_nxt;
      ptr_q   <= ptr_nxt;
      id_q    <= id_nxt;
    end
  end

  assign event_valid = (state_q == PRESENT);
  assign event_id    = id_q;

endmodule
